operand_b_sel: RTL and testbench
================================

Name: operand_b_sel

Overview:
- Parametrised operand-B selector for the Simple CPU v2 datapath. It replaces the single 2:1 memory/IR select with an N-source select plus immediate zero/sign extension.
- The selected operand is registered into a 2-entry skid buffer with valid/ready handshakes on both sides, so the ALU stage can stall without losing operands.
- It sits between the register-file/memory/IR read ports and the ALU B input.

Parameters:
- WIDTH, 8, operand width in bits (>=2).
- NSRC, 4, number of source inputs (2..16).
- SELW, 2, width of src_sel; must satisfy 2**SELW >= NSRC.
- IMM_W, 4, immediate field width; must satisfy 1 <= IMM_W <= WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- src_data  in  NSRC*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH].
- src_sel  in  SELW  source index.
- imm  in  IMM_W  immediate field from IR.
- imm_mode  in  2  operand mode: 00 source, 01 zero-ext imm, 10 sign-ext imm, 11 reserved.
- in_valid  in  1  upstream offers an operand.
- in_ready  out  1  block can accept.
- b  out  WIDTH  registered operand to ALU.
- b_valid  out  1  b holds a valid operand.
- b_ready  in  1  ALU consumes b this cycle.
- sel_err  out  1  sticky error flag.
- err_clr  in  1  synchronous clear of sel_err.

Behaviour:
- Operand formation (combinational):
  - mode 00: src_data slice at src_sel; if src_sel >= NSRC, the operand is all zeros.
  - mode 01: {zeros, imm}.
  - mode 10: imm[IMM_W-1] replicated into the upper bits.
  - mode 11: all zeros.
  - When IMM_W == WIDTH, modes 01 and 10 both pass imm unchanged.
- Accept: in_valid && in_ready at a rising edge. Consume: b_valid && b_ready at a rising edge.
- Latency: an operand accepted in cycle n appears on b with b_valid=1 in cycle n+1, if the buffer was empty or drained that cycle.
- State machine: EMPTY, ONE, TWO. Storage is a main register (drives b) and a skid register.
- EMPTY:
  - b_valid=0, in_ready=1.
  - On accept: main <= operand, go to ONE.
- ONE:
  - b_valid=1, in_ready=1.
  - Accept and consume: main <= operand, stay in ONE.
  - Accept, no consume: skid <= operand, go to TWO.
  - Consume, no accept: go to EMPTY; main retains its last value.
  - Neither: hold.
- TWO:
  - b_valid=1, in_ready=0; in_valid is ignored.
  - On consume: main <= skid, go to ONE.
- in_ready is decoded from the state register only; it has no combinational path from b_ready.
- Ordering: operands leave strictly in acceptance order. None is dropped or duplicated.
- b is stable while b_valid=1 and b_ready=0.
- sel_err:
  - Set on an accept whose operand was an error: mode 00 with src_sel >= NSRC, or mode 11.
  - Cleared by err_clr=1 at a clock edge.
  - If set and clear happen in the same cycle, set wins.
  - Non-accepted cycles never set it.
- Reset (rst_n low, asynchronous):
  - state=EMPTY; main=0; skid=0; b=0; b_valid=0; sel_err=0.
  - in_ready reads 1 (EMPTY decode), but no accept is taken while rst_n is low.
- Reset mid-operation: buffered operands are discarded and b_valid drops immediately. The first edge after rst_n rises behaves as EMPTY.
- src_data, src_sel, imm and imm_mode are sampled only on accepting edges.

Test Plan:
- Basic select (defaults): src_data={8'h44,8'h33,8'h22,8'h11}, sel=2, mode 00, one accept with b_ready=1 -> next cycle b=8'h33, b_valid=1, sel_err=0.
- Immediate extension: imm=4'hA, mode 01 -> b=8'h0A. Same imm, mode 10 -> b=8'hFA. imm=4'h5, mode 10 -> b=8'h05.
- Backpressure/skid: hold b_ready=0 and accept 8'h11 then 8'h22.
  - Required: in_ready=0 in TWO, and a third offer 8'h33 is not accepted.
  - Then raise b_ready: b=8'h11, then 8'h22, then 8'h33 after re-offer. No loss or duplication.
- Streaming: in_valid=1 and b_ready=1 every cycle for 10 cycles with sequence 0..9 -> b follows one cycle behind, b_valid stays 1, state stays ONE, in_ready stays 1.
- Error flag (NSRC=3, SELW=2): sel=3, mode 00, accepted -> b=0, sel_err=1 and stays set. Then err_clr=1 together with a mode-11 accept -> sel_err remains 1. Then err_clr alone -> sel_err=0.
- Async reset: reach TWO, then pulse rst_n low mid-cycle -> b_valid=0, b=0, sel_err=0 immediately. After release, one accept of 8'h5A -> b=8'h5A next cycle.

Source files
------------

// File: rtl/operand_b_sel.sv
// Purpose : N-source / immediate operand-B selector feeding the ALU through a 2-entry skid buffer.
// Latency : an operand accepted at edge n is on b with b_valid=1 right after that edge (cycle n+1).
// Backpr. : in_ready is decoded from state only (low when both entries are full); b holds while b_ready=0.
//
// Ports:
//   clk, rst_n            clock (rising) and asynchronous active-low reset
//   src_data, src_sel     packed sources (source k at [k*WIDTH +: WIDTH]) and source index
//   imm, imm_mode         IR immediate and mode (00 src, 01 zero-ext, 10 sign-ext, 11 reserved)
//   in_valid / in_ready   upstream handshake
//   b, b_valid / b_ready  registered operand to the ALU and its handshake
//   sel_err, err_clr      sticky bad-select flag and its synchronous clear
module operand_b_sel #(
  parameter int WIDTH = 8,
  parameter int NSRC  = 4,
  parameter int SELW  = 2,
  parameter int IMM_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [SELW-1:0]       src_sel,
  input  logic [IMM_W-1:0]      imm,
  input  logic [1:0]            imm_mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      b,
  output logic                  b_valid,
  input  logic                  b_ready,
  output logic                  sel_err,
  input  logic                  err_clr
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             sel_err_q, sel_err_d;

  logic [WIDTH-1:0] src_pick;
  logic             src_hit;
  logic [WIDTH-1:0] imm_zext;
  logic [WIDTH-1:0] imm_sext;
  logic [WIDTH-1:0] operand;
  logic             operand_err;
  logic             accept;
  logic             consume;

  // Source mux; an index past the last source matches nothing and yields zero.
  always_comb begin
    src_pick = '0;
    src_hit  = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (src_sel == SELW'(k)) begin
        src_pick = src_data[k*WIDTH +: WIDTH];
        src_hit  = 1'b1;
      end
    end
  end

  // A zero-width replication is illegal, so a full-width immediate is passed straight through.
  generate
    if (IMM_W == WIDTH) begin : g_imm_full
      assign imm_zext = imm;
      assign imm_sext = imm;
    end else begin : g_imm_ext
      assign imm_zext = {{(WIDTH-IMM_W){1'b0}}, imm};
      assign imm_sext = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
    end
  endgenerate

  always_comb begin
    operand     = '0;
    operand_err = 1'b0;
    case (imm_mode)
      2'b00: begin
        operand     = src_hit ? src_pick : '0;
        operand_err = !src_hit;
      end
      2'b01:   operand = imm_zext;
      2'b10:   operand = imm_sext;
      default: operand_err = 1'b1;
    endcase
  end

  // Handshake outputs come only from the state register.
  assign in_ready = (state_q != ST_TWO);
  assign b_valid  = (state_q != ST_EMPTY);
  assign b        = main_q;
  assign sel_err  = sel_err_q;

  assign accept  = in_valid && in_ready;
  assign consume = b_valid && b_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = operand;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          main_d = operand;
        end else if (accept) begin
          skid_d  = operand;
          state_d = ST_TWO;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (consume) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Set has priority over clear so an error accepted alongside err_clr is not lost.
  always_comb begin
    sel_err_d = sel_err_q;
    if (err_clr) begin
      sel_err_d = 1'b0;
    end
    if (accept && operand_err) begin
      sel_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      sel_err_q <= sel_err_d;
    end
  end

endmodule

// File: tb/tb_operand_b_sel.sv
module tb_operand_b_sel;

  logic        clk;
  logic        rst_n;
  logic [31:0] src_data;
  logic [1:0]  src_sel;
  logic [3:0]  imm;
  logic [1:0]  imm_mode;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  b;
  logic        b_valid;
  logic        b_ready;
  logic        sel_err;
  logic        err_clr;

  // Second instance with three sources so an out-of-range select is reachable.
  logic [23:0] src3_data;
  logic [1:0]  src3_sel;
  logic [3:0]  imm3;
  logic [1:0]  imm3_mode;
  logic        in3_valid;
  logic        in3_ready;
  logic [7:0]  b3;
  logic        b3_valid;
  logic        b3_ready;
  logic        sel3_err;
  logic        err3_clr;

  int total;
  int bad;
  logic [7:0] exp_q[$];
  logic       hold_v;
  logic [7:0] hold_b;

  operand_b_sel #(.WIDTH(8), .NSRC(4), .SELW(2), .IMM_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_sel(src_sel),
    .imm(imm), .imm_mode(imm_mode), .in_valid(in_valid), .in_ready(in_ready),
    .b(b), .b_valid(b_valid), .b_ready(b_ready), .sel_err(sel_err), .err_clr(err_clr)
  );

  operand_b_sel #(.WIDTH(8), .NSRC(3), .SELW(2), .IMM_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .src_data(src3_data), .src_sel(src3_sel),
    .imm(imm3), .imm_mode(imm3_mode), .in_valid(in3_valid), .in_ready(in3_ready),
    .b(b3), .b_valid(b3_valid), .b_ready(b3_ready), .sel_err(sel3_err), .err_clr(err3_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Offer one operand; the expected value is queued once the block shows it will take it.
  task automatic send(input logic [1:0] sel, input logic [3:0] im, input logic [1:0] md,
                      input logic [31:0] sd, input logic [7:0] exp);
    src_data = sd;
    src_sel  = sel;
    imm      = im;
    imm_mode = md;
    in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    total++;
    bad++;
    $display("FAIL send_timeout actual=no_accept required=accept exp=%h", exp);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops the scoreboard on every consume and checks b holds while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && b_valid) chk("b_stable", {24'd0, b}, {24'd0, hold_b});
      if (b_valid && b_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output actual=%h required=none", b);
        end else begin
          chk("sb_order", {24'd0, b}, {24'd0, exp_q.pop_front()});
        end
      end
      hold_v = b_valid && !b_ready;
      hold_b = b;
    end
  end

  initial begin
    total = 0; bad = 0; hold_v = 1'b0; hold_b = '0;
    rst_n = 1'b0; in_valid = 1'b0; b_ready = 1'b0; err_clr = 1'b0;
    src_data = '0; src_sel = '0; imm = '0; imm_mode = '0;
    in3_valid = 1'b0; b3_ready = 1'b1; err3_clr = 1'b0;
    src3_data = 24'h332211; src3_sel = '0; imm3 = '0; imm3_mode = '0;

    #12;
    chk("rst_b_valid",  {31'd0, b_valid},  32'd0);
    chk("rst_b",        {24'd0, b},        32'd0);
    chk("rst_sel_err",  {31'd0, sel_err},  32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic select and one-cycle latency.
    b_ready = 1'b1;
    send(2'd2, 4'h0, 2'b00, 32'h44332211, 8'h33);
    in_valid = 1'b0;
    @(negedge clk);
    chk("basic_b_valid", {31'd0, b_valid}, 32'd1);
    chk("basic_b",       {24'd0, b},       32'h33);
    chk("basic_sel_err", {31'd0, sel_err}, 32'd0);
    idle(1);

    // Immediate extension.
    send(2'd0, 4'hA, 2'b01, 32'h0, 8'h0A);
    send(2'd0, 4'hA, 2'b10, 32'h0, 8'hFA);
    send(2'd0, 4'h5, 2'b10, 32'h0, 8'h05);
    idle(2);

    // Backpressure into the skid register.
    b_ready = 1'b0;
    send(2'd0, 4'h0, 2'b00, 32'h11, 8'h11);
    send(2'd0, 4'h0, 2'b00, 32'h22, 8'h22);
    src_data = 32'h33; in_valid = 1'b1;
    @(negedge clk);
    chk("two_in_ready", {31'd0, in_ready}, 32'd0);
    chk("two_b",        {24'd0, b},        32'h11);
    @(posedge clk); #1;
    b_ready = 1'b1;
    @(negedge clk);
    chk("two_no_comb_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    send(2'd0, 4'h0, 2'b00, 32'h33, 8'h33);
    idle(4);
    chk("skid_drained", exp_q.size(), 32'd0);

    // Streaming 0..9 with both sides always ready.
    for (int i = 0; i < 10; i++) begin
      send(2'd1, 4'h0, 2'b00, {16'h0, i[7:0], 8'hEE}, i[7:0]);
      chk("stream_b_valid",  {31'd0, b_valid},  32'd1);
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    idle(3);

    // Reserved mode sets the sticky flag; a later idle cycle keeps it; err_clr clears it.
    send(2'd0, 4'h7, 2'b11, 32'hFFFFFFFF, 8'h00);
    idle(2);
    chk("mode11_err_sticky", {31'd0, sel_err}, 32'd1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("mode11_err_clr", {31'd0, sel_err}, 32'd0);

    // Out-of-range select on the three-source instance.
    src3_sel = 2'd3; imm3_mode = 2'b00; in3_valid = 1'b1;
    @(posedge clk); #1;
    in3_valid = 1'b0;
    @(negedge clk);
    chk("oor_b",     {24'd0, b3},       32'h00);
    chk("oor_valid", {31'd0, b3_valid}, 32'd1);
    chk("oor_err",   {31'd0, sel3_err}, 32'd1);
    @(posedge clk); #1;
    chk("oor_err_sticky", {31'd0, sel3_err}, 32'd1);
    imm3_mode = 2'b11; in3_valid = 1'b1; err3_clr = 1'b1;
    @(posedge clk); #1;
    in3_valid = 1'b0; err3_clr = 1'b0;
    chk("set_beats_clr", {31'd0, sel3_err}, 32'd1);
    err3_clr = 1'b1;
    @(posedge clk); #1;
    err3_clr = 1'b0;
    chk("clr_alone", {31'd0, sel3_err}, 32'd0);
    @(posedge clk); #1;
    chk("no_accept_no_set", {31'd0, sel3_err}, 32'd0);
    src3_sel = 2'd2; imm3_mode = 2'b00; in3_valid = 1'b1;
    @(posedge clk); #1;
    in3_valid = 1'b0;
    chk("src3_last", {24'd0, b3}, 32'h33);

    // Asynchronous reset with both entries full and the flag set.
    b_ready = 1'b0;
    send(2'd0, 4'h0, 2'b11, 32'h0, 8'h00);
    send(2'd0, 4'h0, 2'b00, 32'h77, 8'h77);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_b_valid", {31'd0, b_valid}, 32'd0);
    chk("arst_b",       {24'd0, b},       32'd0);
    chk("arst_sel_err", {31'd0, sel_err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    b_ready = 1'b1;
    send(2'd3, 4'h0, 2'b00, 32'h5A000000, 8'h5A);
    in_valid = 1'b0;
    chk("post_rst_b",     {24'd0, b},       32'h5A);
    chk("post_rst_valid", {31'd0, b_valid}, 32'd1);
    idle(3);
    chk("final_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
